// File: rtl/mn_matrix_loader_if.sv
// Valid/ready word stream feeding the matrix loader.
// master drives words; slave (the loader) drives ready.
interface mn_matrix_loader_if #(
  parameter int DW = 32
);
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/mn_matrix_loader.sv
// Turns a word stream into row-major m x n matrix-store write cycles.
// Optional running checksum output when LOADER_CHECKSUM_EN is defined.
module mn_matrix_loader #(
  parameter int DW      = 32,
  parameter int AW      = 8,
  parameter int MAX_DIM = 128
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic [AW-1:0] m_dim,
  input  logic [AW-1:0] n_dim,
  mn_matrix_loader_if.slave stream,
  output logic          mat_write,
  output logic [AW-1:0] mat_m_addr,
  output logic [AW-1:0] mat_n_addr,
  output logic [DW-1:0] mat_data,
  output logic          busy,
  output logic          done,
  output logic          err_dim
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [DW-1:0] checksum
`endif
);

  typedef enum logic {IDLE, LOAD} state_t;

  localparam logic [AW-1:0] ONE   = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   MAX_W = (AW+1)'(MAX_DIM);

  state_t        state_reg, state_next;
  logic [AW-1:0] row_reg, row_next;
  logic [AW-1:0] col_reg, col_next;
  logic [AW-1:0] m_reg, m_next;
  logic [AW-1:0] n_reg, n_next;
  logic          wr_reg, wr_next;
  logic [AW-1:0] m_addr_reg, m_addr_next;
  logic [AW-1:0] n_addr_reg, n_addr_next;
  logic [DW-1:0] data_reg, data_next;
  logic          done_reg, done_next;
  logic          err_reg, err_next;
`ifdef LOADER_CHECKSUM_EN
  logic [DW-1:0] sum_reg, sum_next;
`endif

  logic dims_bad;
  logic last_col;
  logic last_row;

  assign dims_bad = (m_dim == '0) || (n_dim == '0) ||
                    ({1'b0, m_dim} > MAX_W) || ({1'b0, n_dim} > MAX_W);
  assign last_col = (col_reg == n_reg - ONE);
  assign last_row = (row_reg == m_reg - ONE);

  // Abort blocks the handshake so an aborted cycle can never transfer.
  assign stream.s_ready = (state_reg == LOAD) && !abort && !reset;

  always_comb begin
    state_next  = state_reg;
    row_next    = row_reg;
    col_next    = col_reg;
    m_next      = m_reg;
    n_next      = n_reg;
    wr_next     = 1'b0;
    m_addr_next = m_addr_reg;
    n_addr_next = n_addr_reg;
    data_next   = data_reg;
    done_next   = 1'b0;
    err_next    = 1'b0;
`ifdef LOADER_CHECKSUM_EN
    sum_next    = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (dims_bad) begin
            err_next = 1'b1;
          end else begin
            m_next     = m_dim;
            n_next     = n_dim;
            row_next   = '0;
            col_next   = '0;
            state_next = LOAD;
`ifdef LOADER_CHECKSUM_EN
            sum_next   = '0;
`endif
          end
        end
      end
      LOAD: begin
        if (abort) begin
          state_next = IDLE;
          row_next   = '0;
          col_next   = '0;
        end else if (stream.s_valid) begin
          wr_next     = 1'b1;
          m_addr_next = row_reg;
          n_addr_next = col_reg;
          data_next   = stream.s_data;
`ifdef LOADER_CHECKSUM_EN
          sum_next    = sum_reg + stream.s_data;
`endif
          if (last_col) begin
            col_next = '0;
            // Final element: wrap the row counter too so it never exceeds m-1.
            if (last_row) begin
              row_next   = '0;
              state_next = IDLE;
              done_next  = 1'b1;
            end else begin
              row_next = row_reg + ONE;
            end
          end else begin
            col_next = col_reg + ONE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      row_reg    <= '0;
      col_reg    <= '0;
      m_reg      <= '0;
      n_reg      <= '0;
      wr_reg     <= 1'b0;
      m_addr_reg <= '0;
      n_addr_reg <= '0;
      data_reg   <= '0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      sum_reg    <= '0;
`endif
    end else begin
      state_reg  <= state_next;
      row_reg    <= row_next;
      col_reg    <= col_next;
      m_reg      <= m_next;
      n_reg      <= n_next;
      wr_reg     <= wr_next;
      m_addr_reg <= m_addr_next;
      n_addr_reg <= n_addr_next;
      data_reg   <= data_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
`ifdef LOADER_CHECKSUM_EN
      sum_reg    <= sum_next;
`endif
    end
  end

  assign mat_write  = wr_reg;
  assign mat_m_addr = m_addr_reg;
  assign mat_n_addr = n_addr_reg;
  assign mat_data   = data_reg;
  assign done       = done_reg;
  assign err_dim    = err_reg;
  assign busy       = (state_reg == LOAD);
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = sum_reg;
`endif

endmodule

// File: tb/tb_mn_matrix_loader.sv
// Bench for mn_matrix_loader: dimension-check table, directed loads and
// randomized loads compared against a row-major index model.
module tb_mn_matrix_loader;

  logic        clk;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  m_dim;
  logic [7:0]  n_dim;
  logic        mat_write;
  logic [7:0]  mat_m_addr;
  logic [7:0]  mat_n_addr;
  logic [31:0] mat_data;
  logic        busy;
  logic        done;
  logic        err_dim;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0] checksum;
`endif

  int tests = 0;
  int fails = 0;

  // Last written values, which the address/data outputs must hold between writes.
  logic [7:0]  last_ma = '0;
  logic [7:0]  last_na = '0;
  logic [31:0] last_d  = '0;

  mn_matrix_loader_if #(.DW(32)) s_if ();

  mn_matrix_loader #(.DW(32), .AW(8), .MAX_DIM(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .abort      (abort),
    .m_dim      (m_dim),
    .n_dim      (n_dim),
    .stream     (s_if.slave),
    .mat_write  (mat_write),
    .mat_m_addr (mat_m_addr),
    .mat_n_addr (mat_n_addr),
    .mat_data   (mat_data),
    .busy       (busy),
    .done       (done),
    .err_dim    (err_dim)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // vmode: 0 valid always, 1 toggling, 2 random. abort_after/start_again < 0 disables.
  task automatic run_load(input int m, input int n, input int vmode, input int abort_after,
                          input int start_again, input bit fixed, input logic [31:0] base);
    int          k = 0;
    int          cyc = 0;
    int          total = m * n;
    bit          finished = 0;
    bit          aborted = 0;
    bit          v;
    bit          ab;
    logic [31:0] d;
    logic [31:0] sum = '0;
    start = 1; m_dim = 8'(m); n_dim = 8'(n);
    @(negedge clk);
    start = 0; m_dim = 8'($urandom); n_dim = 8'($urandom);
    chk("start_busy", busy, 1);
    chk("start_no_err", err_dim, 0);
    chk("start_no_write", mat_write, 0);
`ifdef LOADER_CHECKSUM_EN
    chk("start_checksum_clear", checksum, 0);
`endif
    while (!finished && cyc < total * 3 + 20) begin
      case (vmode)
        0:       v = 1;
        1:       v = (cyc % 2 == 0);
        default: v = 1'($urandom);
      endcase
      d  = fixed ? base + 32'(k) : $urandom;
      ab = (abort_after >= 0) && (k == abort_after);
      start = (cyc == start_again);
      s_if.s_valid = v; s_if.s_data = d; abort = ab;
      #1 chk("s_ready", s_if.s_ready, !ab);
      @(negedge clk);
      start = 0; abort = 0; s_if.s_valid = 0;
      cyc++;
      chk("err_quiet", err_dim, 0);
      if (ab) begin
        chk("abort_no_write", mat_write, 0);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        finished = 1; aborted = 1;
      end else if (v) begin
        chk("write", mat_write, 1);
        chk("m_addr", mat_m_addr, 64'(k / n));
        chk("n_addr", mat_n_addr, 64'(k % n));
        chk("data", mat_data, d);
        chk("done", done, k == total - 1);
        last_ma = 8'(k / n); last_na = 8'(k % n); last_d = d;
        sum += d;
        k++;
        if (k == total) begin
          chk("done_busy_low", busy, 0);
          finished = 1;
        end
      end else begin
        chk("idle_write", mat_write, 0);
        chk("idle_done", done, 0);
        chk("gap_busy", busy, 1);
        chk("hold_m_addr", mat_m_addr, last_ma);
        chk("hold_n_addr", mat_n_addr, last_na);
        chk("hold_data", mat_data, last_d);
      end
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, sum);
`endif
    end
    if (!finished) chk("load_timeout", 0, 1);
    #1 chk("after_s_ready", s_if.s_ready, 0);
    $display("[TB] load %0dx%0d: %0d writes%s", m, n, k, aborted ? " (aborted)" : "");
  endtask

  typedef struct {
    logic [7:0] m;
    logic [7:0] n;
    bit         err;
  } dim_vec_t;

  dim_vec_t dim_tab[8];

  initial begin
    dim_tab[0] = '{8'd0,   8'd4,   1'b1};
    dim_tab[1] = '{8'd129, 8'd1,   1'b1};
    dim_tab[2] = '{8'd1,   8'd0,   1'b1};
    dim_tab[3] = '{8'd128, 8'd129, 1'b1};
    dim_tab[4] = '{8'd255, 8'd3,   1'b1};
    dim_tab[5] = '{8'd128, 8'd128, 1'b0};
    dim_tab[6] = '{8'd1,   8'd1,   1'b0};
    dim_tab[7] = '{8'd5,   8'd7,   1'b0};

    clk = 0; reset = 1; start = 0; abort = 0; m_dim = '0; n_dim = '0;
    s_if.s_valid = 0; s_if.s_data = '0;
    #3;
    chk("rst_write", mat_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err_dim, 0);
    chk("rst_s_ready", s_if.s_ready, 0);
    chk("rst_addr", {mat_m_addr, mat_n_addr}, 0);
    chk("rst_data", mat_data, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;
    @(negedge clk);

    run_load(2, 3, 0, -1, -1, 1, 32'd1);
`ifdef LOADER_CHECKSUM_EN
    chk("checksum_21", checksum, 21);
`endif

    for (int i = 0; i < 8; i++) begin
      start = 1; m_dim = dim_tab[i].m; n_dim = dim_tab[i].n;
      @(negedge clk);
      start = 0;
      chk("dim_err", err_dim, dim_tab[i].err);
      chk("dim_busy", busy, !dim_tab[i].err);
      chk("dim_no_write", mat_write, 0);
      abort = 1;
      @(negedge clk);
      abort = 0;
      chk("dim_err_pulse", err_dim, 0);
      chk("dim_idle", busy, 0);
      $display("[TB] dims %0dx%0d: err_dim expected %0d", dim_tab[i].m, dim_tab[i].n, dim_tab[i].err);
    end

    run_load(3, 3, 1, -1, -1, 1, 32'd100);
    run_load(4, 4, 0, 5, -1, 0, 32'd0);
    run_load(1, 1, 0, -1, -1, 1, 32'hDEADBEEF);

    // Reset in the middle of a 2x2 load.
    start = 1; m_dim = 8'd2; n_dim = 8'd2;
    @(negedge clk);
    start = 0;
    s_if.s_valid = 1; s_if.s_data = 32'h11;
    @(negedge clk);
    chk("pre_rst_write0", mat_write, 1);
    s_if.s_data = 32'h22;
    @(negedge clk);
    chk("pre_rst_write1", mat_n_addr, 1);
    #2 reset = 1;
    #1;
    chk("mid_rst_write", mat_write, 0);
    chk("mid_rst_addr", {mat_m_addr, mat_n_addr}, 0);
    chk("mid_rst_data", mat_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_if.s_ready, 0);
    @(negedge clk);
    reset = 0;
    last_ma = '0; last_na = '0; last_d = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_no_write", mat_write, 0);
      chk("post_rst_idle", busy, 0);
    end
    s_if.s_valid = 0;
    $display("[TB] reset mid-load: no writes after release");
    run_load(2, 2, 2, -1, -1, 0, 32'd0);

    for (int r = 0; r < 6; r++) begin
      int mm = $urandom_range(1, 6);
      int nn = $urandom_range(1, 6);
      int ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, mm * nn - 1) : -1;
      run_load(mm, nn, 2, ab, -1, 0, 32'd0);
    end

    run_load(128, 128, 0, -1, 300, 0, 32'd0);
    chk("last_m_addr", mat_m_addr, 127);
    chk("last_n_addr", mat_n_addr, 127);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mn_matrix_loader.md
Name: mn_matrix_loader

Overview:
- Upstream feeder for the m×n matrix store.
- Accepts a valid/ready stream of 32-bit words and turns it into row-major write cycles: write strobe, m/n address and data.
- Latches dimensions on start, checks them, counts rows and columns, and flags completion.
- Sits between the host/DMA word stream and the matrix store's write, m_addr, n_addr and data_in inputs in the LU solve datapath.

Parameters:
- DW, 32, data word width.
- AW, 8, address and dimension width.
- MAX_DIM, 128, largest legal m_dim/n_dim; must be ≤ 2^AW.

Ports:
- clk  input  1  clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; sampled in IDLE only.
- abort  input  1  synchronous cancel of a load in progress.
- m_dim  input  AW  row count, latched on accepted start.
- n_dim  input  AW  column count, latched on accepted start.
- s_valid  input  1  stream word valid.
- s_data  input  DW  stream word.
- s_ready  output  1  loader can take a word.
- mat_write  output  1  write strobe to matrix store.
- mat_m_addr  output  AW  row address.
- mat_n_addr  output  AW  column address.
- mat_data  output  DW  write data.
- busy  output  1  high while in LOAD.
- done  output  1  one-cycle pulse on final write.
- err_dim  output  1  one-cycle pulse on rejected start.

Behaviour:
- Reset is asynchronous, active-high, clock clk.
  - On reset: state=IDLE; row/col counters and latched dims = 0; mat_write, mat_m_addr, mat_n_addr, mat_data, done, err_dim, busy all 0.
  - s_ready = 0 while reset is asserted.
  - Reset mid-load discards the remainder; no write strobe follows reset release.
- States:
  - IDLE: s_ready=0, busy=0. If start=1:
    - m_dim or n_dim is 0, or either > MAX_DIM: err_dim=1 next cycle, stay IDLE.
    - Otherwise latch m_dim/n_dim, clear row=col=0, go LOAD. busy=1 from the next cycle.
  - LOAD:
    - s_ready is combinational: (state==LOAD) && !abort.
    - A transfer occurs when s_valid && s_ready.
    - abort=1: go IDLE next cycle, no transfer that cycle, counters cleared, done not asserted.
- Transfer timing:
  - Write latency is 1 cycle. The cycle after a transfer: mat_write=1, mat_m_addr=row, mat_n_addr=col, mat_data=s_data as sampled.
  - With no transfer: mat_write=0. Address/data hold their last values.
- Counter update per transfer:
  - col<n-1: col+1.
  - Otherwise col=0 and row+1.
- Final element (row==m-1 && col==n-1):
  - The transfer registers mat_write and done together.
  - State returns to IDLE; s_ready is low in the following cycle.
  - The next start is accepted no earlier than the cycle after done.
- Throughput: one word per cycle with s_valid held high. m×n words produce exactly m×n write strobes, then done.
- start while in LOAD: ignored, dims unchanged.
- s_data while s_ready=0: ignored.
- Counters never exceed latched dims, so addresses always satisfy row<m_dim, col<n_dim.
- m_dim/n_dim changing during LOAD: no effect.
- Simultaneous abort and final transfer: abort wins. No write, no done.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[DW-1:0], the modulo-2^DW sum of all words written in the current load.
  - Cleared on reset and on accepted start.
  - Updated together with each mat_write.
  - Holds its value after done until the next accepted start; abort leaves it frozen.
- Not defined: port absent, no adder logic.

Test Plan:
- Reset, then start m=2 n=3 with s_valid held high and data 1..6 → writes at (0,0)=1, (0,1)=2, (0,2)=3, (1,0)=4, (1,1)=5, (1,2)=6 on consecutive cycles; done high with the (1,2) write; busy low the next cycle; checksum=21 if enabled.
- start m=0 n=4, then start m=129 n=1 → err_dim pulse for each, busy stays 0, no mat_write.
- m=3 n=3 with s_valid toggled 1,0,1,0… → exactly 9 writes in row-major order, gaps matching s_valid low cycles, a single done.
- m=4 n=4, abort asserted after 5 transfers → 5 writes only, no done, IDLE next cycle; a new start m=1 n=1 with data 0xDEADBEEF → write (0,0)=0xDEADBEEF and done.
- Reset asserted mid-load (m=2 n=2, after 2 words) → all outputs 0 immediately, no further writes; after release a fresh 2×2 load completes normally.
- start pulsed again during a 128×128 load → ignored; 16384 writes; last address (127,127); done once.
